// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer block: register offsets, control
// and status bit positions, and the CTRL register layout.
package bus_timer_pkg;

    localparam logic [2:0] REG_CNT_LO   = 3'd0;
    localparam logic [2:0] REG_CNT_HI   = 3'd1;
    localparam logic [2:0] REG_CTRL     = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_CONT = 1;
    localparam int CTRL_IE   = 2;
    localparam int STATUS_IF = 0;

    // Field order puts en at bit 0, matching the CTRL register layout.
    typedef struct packed {
        logic ie;
        logic cont;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler for bus_timer: while enabled it counts down and emits a
// one-cycle tick on reaching zero, giving a tick every reload_value+1 clocks.
module timer_prescaler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         reload,
    input  logic [W-1:0] reload_value,
    output logic         tick
);

    logic [W-1:0] count;

    assign tick = enable & (count == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order across always blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (reload) begin
            count <= reload_value;
        end else if (enable) begin
            count <= tick ? reload_value : count - 1'b1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 16-bit interval timer on the 6502 bus: 8-byte register
// window, prescaled down-counter with one-shot/continuous modes and an IRQ.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hD000,
    parameter int          PRESCALE_W = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_phi2,
    input  logic        i_rw,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        o_sel,
    output logic        o_irq_n
);

    logic                  phi2_q;
    logic                  acc;
    logic                  wr;
    logic                  rd;
    logic [2:0]            offset;
    logic [15:0]           counter;
    logic [15:0]           latch;
    logic [7:0]            snap_hi;
    ctrl_t                 ctrl;
    logic                  irq_flag;
    logic [PRESCALE_W-1:0] prescale;
    logic [7:0]            prescale_ext;
    logic                  tick;
    logic                  presc_reload;
    logic                  underflow;
    logic                  wr_cnt_lo, wr_cnt_hi, wr_ctrl, wr_status, wr_prescale;
    logic                  rd_cnt_lo, rd_status;
    logic                  if_clear;

    assign offset = i_addr[2:0];
    assign o_sel  = (i_addr[15:3] == BASE_ADDR[15:3]);

    // Only the first clock of each phi2-high phase counts as an access.
    assign acc = o_sel & i_phi2 & ~phi2_q;
    assign wr  = acc & ~i_rw;
    assign rd  = acc & i_rw;

    assign wr_cnt_lo   = wr & (offset == REG_CNT_LO);
    assign wr_cnt_hi   = wr & (offset == REG_CNT_HI);
    assign wr_ctrl     = wr & (offset == REG_CTRL);
    assign wr_status   = wr & (offset == REG_STATUS);
    assign wr_prescale = wr & (offset == REG_PRESCALE);
    assign rd_cnt_lo   = rd & (offset == REG_CNT_LO);
    assign rd_status   = rd & (offset == REG_STATUS);

    assign presc_reload = wr_cnt_hi | (wr_ctrl & i_data[CTRL_EN]);
    assign if_clear     = wr_cnt_hi | rd_status | (wr_status & i_data[STATUS_IF]);

    // A CNT_HI load swallows a coincident tick, so no underflow can occur then.
    assign underflow = tick & (counter == 16'h0000) & ~wr_cnt_hi;

    timer_prescaler #(
        .W (PRESCALE_W)
    ) u_prescaler (
        .clk          (i_clk),
        .reset        (i_reset),
        .enable       (ctrl.en),
        .reload       (presc_reload),
        .reload_value (prescale),
        .tick         (tick)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phi2_q   <= 1'b0;
            counter  <= '0;
            latch    <= '0;
            snap_hi  <= '0;
            ctrl     <= '0;
            irq_flag <= 1'b0;
            prescale <= '0;
            o_irq_n  <= 1'b1;
        end else begin
            phi2_q  <= i_phi2;
            o_irq_n <= ~(irq_flag & ctrl.ie);

            if (wr_cnt_lo) latch[7:0] <= i_data;

            if (wr_cnt_hi) begin
                latch[15:8] <= i_data;
                counter     <= {i_data, latch[7:0]};
            end else if (tick) begin
                if (counter != 16'h0000) counter <= counter - 16'd1;
                else if (ctrl.cont)      counter <= latch;
            end

            if (rd_cnt_lo) snap_hi <= counter[15:8];

            // A one-shot stops itself; an explicit CTRL write below still wins.
            if (underflow && !ctrl.cont) ctrl.en <= 1'b0;
            if (wr_ctrl) ctrl <= ctrl_t'(i_data[2:0]);

            if (underflow)     irq_flag <= 1'b1;
            else if (if_clear) irq_flag <= 1'b0;

            if (wr_prescale) prescale <= i_data[PRESCALE_W-1:0];
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block leaves it holding a value (no latch).
    always_comb begin
        prescale_ext                   = '0;
        prescale_ext[PRESCALE_W-1:0]   = prescale;
        o_data                         = 8'h00;
        case (offset)
            REG_CNT_LO:   o_data = counter[7:0];
            REG_CNT_HI:   o_data = snap_hi;
            REG_CTRL:     o_data = {5'b00000, ctrl};
            REG_STATUS:   o_data = {7'b0000000, irq_flag};
            REG_PRESCALE: o_data = prescale_ext;
            default:      o_data = 8'h00;
        endcase
    end

endmodule
